// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel sine DDS: sweep FSM states,
// offset-binary mid-scale and quarter-wave folding of a full-wave phase.
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOK,
    ST_CAP,
    ST_DONE
  } state_e;

  function automatic int mid_val(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  // Folds a full-wave phase into a quarter-wave LUT index; odd quadrants run the table backwards.
  function automatic logic [31:0] fold_index(input logic [31:0] p, input int addr_w);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w - 2)) - 32'd1;
    return p[addr_w-2] ? (~p & mask) : (p & mask);
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine magnitude ROM with a registered (one-cycle) read port.
// Contents are computed at elaboration: round((2^(DATA_W-1)-1) * sin(2*pi*(i+0.5)/2^ADDR_W)).
module sine_qlut #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] addr,
  output logic [DATA_W-2:0] rdata
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  function automatic logic [DATA_W-2:0] lut_entry(input int i);
    real ang;
    real full;
    ang  = 2.0 * 3.14159265358979 * (real'(i) + 0.5) / (2.0 ** ADDR_W);
    full = (2.0 ** (DATA_W - 1)) - 1.0;
    return (DATA_W-1)'($rtoi(full * $sin(ang) + 0.5));
  endfunction

  logic [DATA_W-2:0] rom [DEPTH];
  logic [DATA_W-2:0] rdata_d;
  logic [DATA_W-2:0] rdata_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = lut_entry(gi);
  end

  assign rdata_d = rom[addr];

  // NOTE: the ROM read register carries no reset so it maps onto block RAM output registers;
  // its value is only consumed in CAP, one cycle after LOOK has presented a valid address.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sine_dds_multich.sv
// Multi-channel DDS: one shared phase accumulator, per-channel offsets, time-shared quarter-wave LUT.
// Optional DDS_AMP_SCALE_EN adds an 8-bit amplitude (modulation index) port scaling every lane.
module sine_dds_multich
  import dds_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   tick,
  input  logic [ACC_W-1:0]       phase_inc,
  input  logic [N_CH*ADDR_W-1:0] ch_offset,
`ifdef DDS_AMP_SCALE_EN
  input  logic [7:0]             amp,
`endif
  output logic [N_CH*DATA_W-1:0] sample,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int                CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int                LUT_AW  = ADDR_W - 2;
  localparam logic [DATA_W-1:0] MID     = DATA_W'(mid_val(DATA_W));
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CH_W-1:0]        k_q, k_d;
  logic                   q1_q, q1_d;
  logic [DATA_W-1:0]      shadow_q [N_CH];
  logic [DATA_W-1:0]      shadow_d [N_CH];
  logic [N_CH*DATA_W-1:0] sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic [ADDR_W-1:0]      off_sel;
  logic [ADDR_W-1:0]      phase;
  logic [31:0]            fold_w;
  logic [31-LUT_AW:0]     fold_unused;
  logic [LUT_AW-1:0]      lut_addr;
  logic [DATA_W-2:0]      lut_data;
  logic [DATA_W-2:0]      mag;

  always_comb begin
    off_sel = ch_offset[ADDR_W-1:0];
    for (int i = 1; i < N_CH; i++) begin
      if (k_q == CH_W'(i)) off_sel = ch_offset[i*ADDR_W +: ADDR_W];
    end
  end

  assign phase       = acc_q[ACC_W-1 -: ADDR_W] + off_sel;
  assign fold_w      = fold_index(32'(phase), ADDR_W);
  assign lut_addr    = fold_w[LUT_AW-1:0];
  assign fold_unused = fold_w[31:LUT_AW];

  sine_qlut #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lut (
    .clk   (clk),
    .addr  (lut_addr),
    .rdata (lut_data)
  );

`ifdef DDS_AMP_SCALE_EN
  logic [7:0]        amp_q, amp_d;
  logic [DATA_W+6:0] prod;
  logic [7:0]        prod_frac_unused;

  assign amp_d            = (en && tick && state_q == ST_IDLE) ? amp : amp_q;
  assign prod             = (DATA_W+7)'(lut_data) * (DATA_W+7)'(amp_q);
  assign mag              = prod[DATA_W+6:8];
  assign prod_frac_unused = prod[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) amp_q <= '0;
    else        amp_q <= amp_d;
  end
`else
  assign mag = lut_data;
`endif

  // NOTE: every output of this block is assigned a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_d       = k_q;
    q1_d      = q1_q;
    shadow_d  = shadow_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (!en) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      k_d       = '0;
      overrun_d = 1'b0;
    end else begin
      if (tick && state_q != ST_IDLE) overrun_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (tick) begin
            acc_d   = acc_q + phase_inc;
            k_d     = '0;
            state_d = ST_LOOK;
          end
        end
        ST_LOOK: begin
          q1_d    = phase[ADDR_W-1];
          state_d = ST_CAP;
        end
        ST_CAP: begin
          for (int i = 0; i < N_CH; i++) begin
            if (k_q == CH_W'(i)) shadow_d[i] = q1_q ? MID - {1'b0, mag} : MID + {1'b0, mag};
          end
          if (k_q == LAST_CH) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_LOOK;
          end
        end
        ST_DONE: begin
          for (int i = 0; i < N_CH; i++) sample_d[i*DATA_W +: DATA_W] = shadow_q[i];
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      k_q       <= '0;
      q1_q      <= 1'b0;
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= MID;
      sample_q  <= {N_CH{MID}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      q1_q      <= q1_d;
      shadow_q  <= shadow_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sine_dds_multich.sv
// Scoreboard bench for sine_dds_multich (3 channels, 8-bit samples): stimulus pushes expected
// banks and their arrival cycle, a negedge monitor pops and compares on every sample_valid.
module tb_sine_dds_multich;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        tick;
  logic [31:0] phase_inc;
  logic [47:0] ch_offset;
  logic [23:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
`ifdef DDS_AMP_SCALE_EN
  logic [7:0]  amp;
`endif

  always #5 clk = ~clk;

  sine_dds_multich #(
    .N_CH   (3),
    .ACC_W  (32),
    .ADDR_W (16),
    .DATA_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .tick         (tick),
    .phase_inc    (phase_inc),
    .ch_offset    (ch_offset),
`ifdef DDS_AMP_SCALE_EN
    .amp          (amp),
`endif
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    logic [23:0] bank;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Hand-derived lane value: MID +/- LUT magnitude (127 at a quadrant peak, 0 at a zero crossing).
  function automatic logic [7:0] lane(input bit neg, input int m);
    int s;
    s = m;
`ifdef DDS_AMP_SCALE_EN
    s = (m * int'(amp)) >> 8;
`endif
    return neg ? 8'(128 - s) : 8'(128 + s);
  endfunction

  function automatic logic [23:0] rep3(input logic [7:0] v);
    return {v, v, v};
  endfunction

  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(sample_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("bank", 32'(sample), 32'(mon_e.bank));
        check("latency", cyc, mon_e.cyc);
        check("busy_in_valid", 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue_tick(input logic [23:0] bank, input bit expect_valid);
    @(negedge clk);
    tick = 1'b1;
    if (expect_valid) exp_q.push_back('{bank: bank, cyc: cyc + 8});
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [4];

    rst_n     = 1'b0;
    en        = 1'b0;
    tick      = 1'b0;
    phase_inc = '0;
    ch_offset = '0;
`ifdef DDS_AMP_SCALE_EN
    amp       = 8'd255;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_sample", 32'(sample), 32'h80_8080);
    check("reset_valid", 32'(sample_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    en = 1'b1;

    // Static phase, offsets 0 / 90 / 270 degrees.
    ch_offset = {16'hC000, 16'h4000, 16'h0000};
    issue_tick({lane(1'b1, 127), lane(1'b0, 127), lane(1'b0, 0)}, 1'b1);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_drain("drain_offsets");

    // Quarter-turn steps through all quadrants and the accumulator wrap.
    phase_inc = 32'h4000_0000;
    ch_offset = '0;
    seq[0] = lane(1'b0, 127);
    seq[1] = lane(1'b1, 0);
    seq[2] = lane(1'b1, 127);
    seq[3] = lane(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      issue_tick(rep3(seq[i]), 1'b1);
      repeat (18) @(negedge clk);
    end
    wait_drain("drain_steps");
    check("no_overrun_spaced", 32'(overrun), 32'd0);

    // Tick during a sweep: ignored, sets sticky overrun.
    issue_tick(rep3(lane(1'b0, 127)), 1'b1);
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_drain("drain_overrun");
    check("overrun_sticky", 32'(overrun), 32'd1);
    issue_tick(rep3(lane(1'b1, 0)), 1'b1);
    wait_drain("drain_single_step");

    // en low: clears overrun and accumulator, ignores tick, holds sample.
    @(negedge clk);
    en   = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("en_clears_overrun", 32'(overrun), 32'd0);
    check("en_busy", 32'(busy), 32'd0);
    check("en_holds_sample", 32'(sample), 32'h80_8080);
    @(negedge clk);
    en = 1'b1;
    issue_tick(rep3(lane(1'b0, 127)), 1'b1);
    wait_drain("drain_after_en");

    // Reset in the middle of a sweep.
    issue_tick(24'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_mid_sweep", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sample", 32'(sample), 32'h80_8080);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(sample_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_pending", exp_q.size(), 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);

`ifdef DDS_AMP_SCALE_EN
    phase_inc = '0;
    ch_offset = {16'h0000, 16'h0000, 16'h4000};
    amp       = 8'd128;
    issue_tick({8'd128, 8'd128, 8'd191}, 1'b1);
    wait_drain("drain_amp_half");
    amp = 8'd0;
    issue_tick(24'h80_8080, 1'b1);
    wait_drain("drain_amp_zero");
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
